// File: rtl/rst_seq_sync.sv
// Purpose : reset synchroniser plus ordered release sequencer for the CLK domain.
// Latency : Sync_RST[k] releases NUM_STAGES+1+HOLD+k*GAP edges after RST rises.
// Backpr. : none; SW_RST_REQ is a level that holds every output in reset while high.
//
// Ports
//   CLK         clock
//   RST         async active-low reset; assertion clears everything immediately
//   SW_RST_REQ  synchronous active-high software reset request (level)
//   Sync_RST    NUM_OUT active-low block resets, 1 = block released
//   RST_Done    high once every Sync_RST bit is released
module rst_seq_sync #(
  parameter int NUM_STAGES = 2,
  parameter int NUM_OUT    = 4,
  parameter int HOLD       = 8,
  parameter int GAP        = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               SW_RST_REQ,
  output logic [NUM_OUT-1:0] Sync_RST,
  output logic               RST_Done
);

  localparam int CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(NUM_OUT + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUT - 1);

  localparam logic [1:0] ST_RESET   = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

  // ---------------------------------------------------------------------------
  // Synchroniser: asserted asynchronously, released after NUM_STAGES edges.
  // The chain is only cleared by RST; a software request leaves it high so the
  // rerun sequence starts from ST_HOLD without an extra synchroniser delay.
  // ---------------------------------------------------------------------------
  logic [NUM_STAGES-1:0] sync_q;
  logic                  sync_n;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[NUM_STAGES-2:0], 1'b1};
    end
  end

  assign sync_n = sync_q[NUM_STAGES-1];

  // ---------------------------------------------------------------------------
  // Release sequencer
  // ---------------------------------------------------------------------------
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_RESET;
      cnt      <= '0;
      idx      <= '0;
      Sync_RST <= '0;
      RST_Done <= 1'b0;
    end else if (SW_RST_REQ) begin
      // Request wins over any sequencing in progress; holding it keeps us here.
      state    <= ST_RESET;
      cnt      <= '0;
      idx      <= '0;
      Sync_RST <= '0;
      RST_Done <= 1'b0;
    end else begin
      case (state)
        ST_RESET: begin
          if (sync_n) begin
            state <= ST_HOLD;
            cnt   <= '0;
          end
        end

        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            Sync_RST[0] <= 1'b1;
            cnt         <= '0;
            idx         <= IW'(1);
            if (NUM_OUT == 1) begin
              RST_Done <= 1'b1;
              state    <= ST_RUN;
            end else begin
              state <= ST_RELEASE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_RELEASE: begin
          if (cnt == GAP_LAST) begin
            // Set only the bit at idx; lower bits are already 1 and stay 1.
            for (int k = 0; k < NUM_OUT; k++) begin
              if (idx == IW'(k)) begin
                Sync_RST[k] <= 1'b1;
              end
            end
            cnt <= '0;
            idx <= idx + IW'(1);
            if (idx == IDX_LAST) begin
              RST_Done <= 1'b1;
              state    <= ST_RUN;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_RUN: begin
          // All outputs released; nothing to do until a reset source fires.
        end

        default: begin
          state    <= ST_RESET;
          cnt      <= '0;
          idx      <= '0;
          Sync_RST <= '0;
          RST_Done <= 1'b0;
        end
      endcase
    end
  end

endmodule
